// File: rtl/or1200_vlx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : or1200_vlx_ctrl_if
// Description : Byte-stream and store-bus bundle for the VLX store sequencer.
//               master : sequencer side (accepts packer bytes, issues stores)
//               slave  : environment side (packer + store unit)
//   byte_valid_i / byte_i / byte_ready_o : packer byte handshake
//   st_req_o / st_addr_o / st_dat_o / st_last_o / st_ack_i : store request bus
// Revision    : 1.0 - initial release
// ============================================================================
interface or1200_vlx_ctrl_if;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        st_req_o;
    logic [31:0] st_addr_o;
    logic [7:0]  st_dat_o;
    logic        st_last_o;
    logic        st_ack_i;

    modport master (
        input  byte_valid_i, byte_i, st_ack_i,
        output byte_ready_o, st_req_o, st_addr_o, st_dat_o, st_last_o
    );

    modport slave (
        output byte_valid_i, byte_i, st_ack_i,
        input  byte_ready_o, st_req_o, st_addr_o, st_dat_o, st_last_o
    );
endinterface
`default_nettype wire

// File: rtl/or1200_vlx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : or1200_vlx_ctrl
// Description : VLX store sequencer. Buffers packed bytes in a small FIFO,
//               issues one-byte stores at an auto-incrementing address and
//               optionally inserts a 0x00 stuffing byte after every 0xFF.
// Ports       : clk_i, rst_ni (async, active-low)
//               spr_we_i/spr_addr_i/spr_dat_i/spr_dat_o : SPR access
//                 0 = BASE, 1 = CTRL (bit0 = flush), 2 = STATUS, 3 = COUNT
//               done_o : one-cycle pulse when a flush completes
//               bus    : byte handshake + store bus (master modport)
// Options     : OR1200_VLX_CTRL_STUFF_EN - enables 0x00 stuffing after 0xFF
// Revision    : 1.0 - initial release
// ============================================================================
module or1200_vlx_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    input  wire logic         spr_we_i,
    input  wire logic [1:0]   spr_addr_i,
    input  wire logic [31:0]  spr_dat_i,
    output logic [31:0]       spr_dat_o,
    output logic              done_o,
    or1200_vlx_ctrl_if.master bus
);

`ifdef OR1200_VLX_CTRL_STUFF_EN
    localparam logic STUFF_EN = 1'b1;
`else
    localparam logic STUFF_EN = 1'b0;
`endif

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;   // extra MSB distinguishes full from empty
    logic        fifo_empty, fifo_full;
    logic        push, pop;

    logic [31:0] addr, count;
    logic [7:0]  out_byte;
    logic        flush_pend, done_sticky, err_sticky;

    logic        stuff_next;
    logic        ack_xfer;
    logic        is_idle;
    logic        base_we, base_ok, ctrl_flush, flush_done;
    logic        busy;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = bus.byte_valid_i && !fifo_full;

    assign stuff_next = STUFF_EN && (out_byte == 8'hFF);
    assign ack_xfer   = bus.st_ack_i && (state != IDLE);

    // A BASE write racing a packer push is treated as not idle.
    assign is_idle    = (state == IDLE) && fifo_empty && !flush_pend;
    assign base_we    = spr_we_i && (spr_addr_i == 2'd0);
    assign base_ok    = base_we && is_idle && !push;
    assign ctrl_flush = spr_we_i && (spr_addr_i == 2'd1) && spr_dat_i[0];
    assign flush_done = (state == IDLE) && fifo_empty && flush_pend;
    assign busy       = (state != IDLE) || !fifo_empty;

    assign done_o           = flush_done;
    assign bus.byte_ready_o = !fifo_full;
    assign bus.st_addr_o    = addr;
    assign bus.st_last_o    = flush_pend && fifo_empty &&
                              ((state == STUFF) || ((state == SEND) && !stuff_next));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        pop             = 1'b0;
        bus.st_req_o    = 1'b0;
        bus.st_dat_o    = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                bus.st_req_o = 1'b1;
                bus.st_dat_o = out_byte;
                if (bus.st_ack_i) begin
                    if (stuff_next) begin
                        state_nxt = STUFF;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            STUFF: begin
                bus.st_req_o = 1'b1;
                if (bus.st_ack_i) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage needs no reset; the pointers define its contents.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.byte_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_byte    <= 8'h00;
            addr        <= 32'h0;
            count       <= 32'h0;
            flush_pend  <= 1'b0;
            done_sticky <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_byte <= mem[rd_ptr[AW-1:0]];
            end

            if (base_ok) begin
                addr  <= spr_dat_i;
                count <= 32'h0;
            end else if (ack_xfer) begin
                addr  <= addr + 32'd1;
                count <= count + 32'd1;
            end

            if (base_ok) begin
                done_sticky <= 1'b0;
                err_sticky  <= 1'b0;
            end else if (base_we) begin
                err_sticky  <= 1'b1;
            end

            if (flush_done) begin
                flush_pend  <= 1'b0;
                done_sticky <= 1'b1;
            end
            if (ctrl_flush) flush_pend <= 1'b1;
        end
    end

    always_comb begin
        spr_dat_o = 32'h0;
        case (spr_addr_i)
            2'd0:    spr_dat_o = addr;
            2'd1:    spr_dat_o = 32'h0;
            2'd2:    spr_dat_o = {28'h0, err_sticky, done_sticky, flush_pend, busy};
            default: spr_dat_o = count;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/or1200_vlx_ctrl.md
# or1200_vlx_ctrl

Store sequencer for the VLX (Huffman bit-packer) datapath in the OR1200 JPEG extension. It accepts completed bytes from the packer into a small FIFO and inserts the JPEG 0x00 stuffing byte after every 0xFF. It issues one-byte store requests to the store unit at an auto-incrementing address. Software configures and monitors it through SPRs: base address, flush command, status and byte count.

## Interface
- `FIFO_DEPTH`, default 4, byte FIFO depth; must be a power of 2, ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `spr_we_i` in 1: SPR write strobe, one cycle.
- `spr_addr_i` in 2: SPR select. 0 = BASE, 1 = CTRL, 2 = STATUS (read-only), 3 = COUNT (read-only).
- `spr_dat_i` in 32: SPR write data.
- `spr_dat_o` out 32: SPR read data, combinational on `spr_addr_i`.
- `byte_valid_i` in 1: packer presents a byte.
- `byte_i` in 8: packed byte.
- `byte_ready_o` out 1: `!fifo_full`; a transfer occurs when valid && ready.
- `st_req_o` out 1: store request.
- `st_addr_o` out 32: byte address of the current store.
- `st_dat_o` out 8: byte to store.
- `st_last_o` out 1: current store is the final byte of a flush.
- `st_ack_i` in 1: store unit accepted the request (single cycle).
- `done_o` out 1: one-cycle pulse when a flush completes.

## Operation
- Internal registers:
  - `addr` (32): next store address.
  - `count` (32): bytes stored since last BASE write, stuffing bytes included.
  - `out_byte` (8): byte under request.
  - `flush_pend`, `done_sticky`, `err_sticky`.
- FSM states: IDLE, SEND, STUFF.
  - IDLE: `st_req_o`=0. If the FIFO is non-empty: pop into `out_byte`, go to SEND.
  - SEND: `st_req_o`=1, `st_dat_o`=`out_byte`, `st_addr_o`=`addr`. Without `st_ack_i`, hold everything stable. On ack: `addr`+1, `count`+1.
    - If `out_byte`==0xFF and stuffing is compiled in → STUFF.
    - Else if the FIFO is non-empty → pop next, stay in SEND.
    - Else → IDLE.
  - STUFF: `st_req_o`=1, `st_dat_o`=0x00, `st_addr_o`=`addr`. On ack: `addr`+1, `count`+1; next state chosen as for a non-0xFF SEND ack.
- `st_last_o` = `flush_pend` && FIFO empty && (state==STUFF || (state==SEND && !(`out_byte`==0xFF && stuffing))).
- Flush completion: in IDLE with FIFO empty and `flush_pend`=1:
  - clear `flush_pend`, set `done_sticky`, pulse `done_o` for one cycle;
  - stay in IDLE that cycle.
- SPR writes:
  - BASE: allowed only when idle, i.e. state==IDLE, FIFO empty and `flush_pend`=0. Loads `addr`; clears `count`, `done_sticky`, `err_sticky`. When not idle, the write is ignored and `err_sticky` is set.
  - CTRL bit0=1: sets `flush_pend`. Writing 0 has no effect. Flush on an already-idle block completes on the next cycle.
- STATUS = {28'b0, `err_sticky`, `done_sticky`, `flush_pend`, busy}. busy = state≠IDLE || FIFO non-empty.
- BASE read returns `addr`; COUNT read returns `count`. CTRL reads as 0.
- Arithmetic: `addr` and `count` wrap modulo 2^32 (0xFFFFFFFF+1 → 0) with no flag.
- FIFO: a push is blocked when full (no bypass). Simultaneous push and pop are allowed when neither full nor empty, and the count is unchanged. Ordering is strict FIFO.

## Timing
- Reset (`rst_ni` low, asynchronous) clears all registers and empties the FIFO; state = IDLE.
- Output values during reset: `st_req_o`=0, `st_addr_o`=0, `st_dat_o`=0, `st_last_o`=0, `done_o`=0, `byte_ready_o`=1, `spr_dat_o` follows the reset registers.
- Reset asserted mid-request drops `st_req_o` immediately. Any pending byte is lost.
- Latency: byte accepted at edge N → `st_req_o` high in the cycle after edge N+1, i.e. 2 cycles.
- Back-to-back throughput: with `st_ack_i` tied high, one store per cycle.
- Minimum flush completion: `done_o` rises the cycle after the final ack.
- SPR write takes effect at the clock edge of `spr_we_i`. A BASE write coincident with a packer push counts as not idle and is rejected.

## Configuration
- `OR1200_VLX_CTRL_STUFF_EN`:
  - Defined: a 0x00 store follows every stored 0xFF.
  - Undefined: STUFF is unreachable, 0xFF is stored alone, and `st_last_o` ignores the 0xFF term.

## Test plan
- BASE=0x1000; push 0x12, 0x34; flush → stores 0x12@0x1000, 0x34@0x1001; `st_last_o` on 0x34 only; `done_o` pulse; COUNT=2; STATUS=0x4.
- Stuffing on: push 0xFF, 0xAB; ack delayed 3 cycles each → 0xFF@A, 0x00@A+1, 0xAB@A+2; address/data stable while waiting; COUNT=3. Stuffing off → 2 stores.
- Fill: `st_ack_i`=0, push 6 bytes with `FIFO_DEPTH`=4 → `byte_ready_o` low after 5 accepted (4 in FIFO + 1 in `out_byte`); releasing ack drains all in order.
- Flush with final byte 0xFF (stuffing on) → `st_last_o` asserted only on the 0x00 store.
- BASE write while busy → ignored, STATUS bit3=1, `addr` unchanged. BASE=0xFFFFFFFF followed by 2 stores → second at 0x00000000.
- Assert `rst_ni` low with `st_req_o` high → `st_req_o`=0 asynchronously, STATUS=0, `byte_ready_o`=1.
